// File: rtl/cone_share_arbiter.sv
// rtl/cone_share_arbiter.sv - round-robin sharing of one 4-input logic cone over a 2-stage pipeline (option: CONE_ACTIVITY_CNT_EN)
module cone_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_bit,
  output logic              busy
`ifdef CONE_ACTIVITY_CNT_EN
  ,
  output logic [15:0]       act_cnt
`endif
);

  // f = (b ^ (a & c)) & (a | (c & d)) with ops = {d,c,b,a}
  function automatic logic cone_f(input logic [3:0] ops);
    return (ops[1] ^ (ops[0] & ops[2])) & (ops[0] | (ops[2] & ops[3]));
  endfunction

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  logic [IDW-1:0] ptr;
  logic           s1_valid;
  logic [3:0]     s1_ops;
  logic [IDW-1:0] s1_id;
  logic           s2_valid;

  logic           adv;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] cand;
  logic           accept;
  logic [3:0]     win_ops;
  logic           cone_res;

  assign adv       = ~s2_valid | rsp_ready;
  assign accept    = rst_n & adv & gnt_any;
  assign win_ops   = req_data[{gnt_id, 2'b00} +: 4];
  assign cone_res  = cone_f(s1_ops);
  assign rsp_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

  // rotating priority search starting at ptr; the first valid requester wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_idx(ptr, k);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // grant is presented only when the pipeline can advance and reset is released
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  // pipeline registers; operands and result hold when not loaded to keep the cone quiet
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_ops   <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      rsp_bit  <= 1'b0;
      rsp_id   <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_ops <= win_ops;
        s1_id  <= gnt_id;
        ptr    <= wrap_idx(gnt_id, 1);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        rsp_bit <= cone_res;
        rsp_id  <= s1_id;
      end
    end
  end

`ifdef CONE_ACTIVITY_CNT_EN
  logic [15:0] op_toggle;

  // saturating toggle counters on the result bit (exported) and on the operand register (internal)
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      act_cnt   <= '0;
      op_toggle <= '0;
    end else if (adv) begin
      if (s1_valid && (cone_res != rsp_bit) && (act_cnt != 16'hFFFF))
        act_cnt <= act_cnt + 16'd1;
      if (accept && (win_ops != s1_ops) && (op_toggle != 16'hFFFF))
        op_toggle <= op_toggle + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cone_share_arbiter.sv
// tb/tb_cone_share_arbiter.sv - self-checking bench for cone_share_arbiter
module tb_cone_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_bit;
  logic              busy;
`ifdef CONE_ACTIVITY_CNT_EN
  logic [15:0]       act_cnt;
`endif

  cone_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_bit   (rsp_bit),
    .busy      (busy)
`ifdef CONE_ACTIVITY_CNT_EN
    ,
    .act_cnt   (act_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic           bitv;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0] ops;
    logic       exp;
  } vec_t;
  vec_t vecs[16];

  logic [IDW-1:0]  mptr;
  logic [NREQ-1:0] m_exp_rdy;
  logic            m_adv;
  int              m_w;
  exp_t            m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic model_f(input logic [3:0] v);
    logic a, b, c, d;
    {d, c, b, a} = v;
    return (b ^ (a & c)) & (a | (c & d));
  endfunction

  // reference arbiter + scoreboard, sampled mid-cycle
  always @(negedge clock) begin
    m_exp_rdy = '0;
    if (!rst_n) begin
      sb_q.delete();
      mptr = '0;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
    end else begin
      m_adv = !rsp_valid || rsp_ready;
      if (m_adv) begin
        for (int k = 0; k < NREQ; k++) begin
          m_w = (int'(mptr) + k) % NREQ;
          if (m_exp_rdy == '0 && req_valid[m_w]) m_exp_rdy[m_w] = 1'b1;
        end
      end
      chk("mon_req_ready", 32'(req_ready), 32'(m_exp_rdy));
      if (rsp_valid && rsp_ready) begin
        chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          m_e = sb_q.pop_front();
          chk("sb_rsp_id", 32'(rsp_id), 32'(m_e.id));
          chk("sb_rsp_bit", 32'(rsp_bit), 32'(m_e.bitv));
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (m_exp_rdy[k]) begin
          sb_q.push_back('{id: IDW'(k), bitv: model_f(req_data[4*k +: 4])});
          mptr = IDW'((k + 1) % NREQ);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    rst_n = 1'b0; req_valid = '1; req_data = '1;
    @(negedge clock);
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    rst_n = 1'b1; req_valid = '0; req_data = '0;
    @(negedge clock);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_bit", 32'(rsp_bit), 32'd0);
    chk("rst_ptr", 32'(dut.ptr), 32'd0);
`ifdef CONE_ACTIVITY_CNT_EN
    chk("rst_act_cnt", 32'(act_cnt), 32'd0);
`endif
  endtask

  task automatic single(input int id, input logic [3:0] ops, input logic exp_bit, input string tag);
    @(posedge clock); #1;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_data[4*id +: 4] = ops;
    @(negedge clock);
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    chk({tag, "_early_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_bit"}, 32'(rsp_bit), 32'(exp_bit));
  endtask

  logic [15:0] truth;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    truth = 16'h6828;
    for (int n = 0; n < 16; n++) begin
      vecs[n].ops = 4'(n);
      vecs[n].exp = truth[n];
    end

    do_reset();
    single(0, 4'b0101, 1'b1, "s0a");
    single(0, 4'b0111, 1'b0, "s0b");
    for (int n = 0; n < 16; n++) single(2, vecs[n].ops, vecs[n].exp, $sformatf("tv%0d", n));

    // round-robin with everyone valid
    do_reset();
    @(posedge clock); #1;
    req_valid = 4'b1111; req_data = 16'hE5B3;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      if (j < 6) chk("rr_gnt", 32'(req_ready), 32'(1 << (j % 4)));
      if (j >= 2) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rr_rsp_id", 32'(rsp_id), 32'((j - 2) % 4));
      end
      if (j == 5) begin
        @(posedge clock); #1;
        req_valid = '0;
      end
    end

    // backpressure: two accepts then a 5-cycle stall
    do_reset();
    @(posedge clock); #1;
    rsp_ready = 1'b0; req_valid = 4'b0011; req_data = 16'h0075;
    @(negedge clock);
    chk("bp_gnt0", 32'(req_ready), 32'b0001);
    @(negedge clock);
    chk("bp_gnt1", 32'(req_ready), 32'b0010);
    @(posedge clock); #1;
    req_valid = 4'b0100;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_id", 32'(rsp_id), 32'd0);
      chk("bp_rsp_bit", 32'(rsp_bit), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clock); #1;
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clock);
    chk("bp_drain0_id", 32'(rsp_id), 32'd0);
    chk("bp_drain0_bit", 32'(rsp_bit), 32'd1);
    @(negedge clock);
    chk("bp_drain1_valid", 32'(rsp_valid), 32'd1);
    chk("bp_drain1_id", 32'(rsp_id), 32'd1);
    chk("bp_drain1_bit", 32'(rsp_bit), 32'd0);
    @(negedge clock);
    chk("bp_empty", 32'(rsp_valid), 32'd0);

    // operand isolation while idle
    do_reset();
    single(0, 4'b1011, 1'b1, "iso");
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      chk("iso_ops", 32'(dut.s1_ops), 32'b1011);
      chk("iso_bit", 32'(rsp_bit), 32'd1);
    end

    // reset with both stages full
    @(posedge clock); #1;
    rsp_ready = 1'b0; req_valid = 4'b0011; req_data = 16'h0075;
    @(posedge clock);
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    chk("mid_full_busy", 32'(busy), 32'd1);
    @(posedge clock); #1;
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clock);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ptr", 32'(dut.ptr), 32'd0);
`ifdef CONE_ACTIVITY_CNT_EN
    chk("mid_act_cnt", 32'(act_cnt), 32'd0);
`endif
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      chk("mid_no_stale", 32'(rsp_valid), 32'd0);
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
